// File: rtl/modn_updown_counter_if.sv
// Control/status bundle for one modulo-N up/down counter stage.
//   en, up_dn, load, load_val : driven by the controlling side (master)
//   out, tc, load_err         : driven by the counter (slave)
interface modn_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             load_err;

  modport master (
    output en, up_dn, load, load_val,
    input  out, tc, load_err
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output out, tc, load_err
  );
endinterface

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with synchronous load, optional end saturation and
// a combinational terminal count for cascading stages.
//   clk            : rising-edge clock
//   rst            : asynchronous active-high reset
//   bus.en         : count enable
//   bus.up_dn      : 1 = count up, 0 = count down
//   bus.load       : synchronous load strobe (beats en)
//   bus.load_val   : value to load; out-of-range values load 0 and flag load_err
//   bus.out        : registered count, always in 0..MODULUS-1
//   bus.tc         : combinational terminal count / carry-out
//   bus.load_err   : registered one-cycle out-of-range load flag
module modn_updown_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 10,
  parameter bit          SATURATE = 1'b0
) (
  input logic              clk,
  input logic              rst,
  modn_updown_counter_if.slave bus
);

  localparam longint unsigned CODES = 64'(1) << WIDTH;

  // Reject parameter sets the counter cannot represent.
  if (WIDTH < 1 || WIDTH > 31 || MODULUS < 2 || 64'(MODULUS) > CODES) begin : g_bad_param
    $error("modn_updown_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             at_top, at_bot, in_range;

  assign at_top   = (count_q == TOP);
  assign at_bot   = (count_q == '0);
  // One extra bit so MODULUS = 2**WIDTH accepts every code.
  assign in_range = ({1'b0, bus.load_val} < MOD_EXT);

  // Next count: load beats enable; ends either wrap or hold.
  always_comb begin
    count_d = count_q;
    err_d   = 1'b0;
    if (bus.load) begin
      if (in_range) begin
        count_d = bus.load_val;
      end else begin
        count_d = '0;
        err_d   = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (at_top) count_d = SATURATE ? count_q : '0;
        else        count_d = count_q + WIDTH'(1);
      end else begin
        if (at_bot) count_d = SATURATE ? count_q : TOP;
        else        count_d = count_q - WIDTH'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.out      = count_q;
  assign bus.load_err = err_q;
  // Carry-out is combinational so a cascaded stage counts on the same edge.
  assign bus.tc       = bus.en & ~bus.load & (bus.up_dn ? at_top : at_bot);

endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed self-checking bench: wrap/saturate counters, load handling,
// async reset, a power-of-two modulus and a two-stage decimal cascade.
module tb_modn_updown_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  modn_updown_counter_if #(.WIDTH(4)) b0 ();
  modn_updown_counter_if #(.WIDTH(4)) b1 ();
  modn_updown_counter_if #(.WIDTH(4)) b2 ();
  modn_updown_counter_if #(.WIDTH(4)) bl ();
  modn_updown_counter_if #(.WIDTH(4)) bh ();

  modn_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (.clk(clk), .rst(rst), .bus(b0));
  modn_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat  (.clk(clk), .rst(rst), .bus(b1));
  modn_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_p2   (.clk(clk), .rst(rst), .bus(b2));
  modn_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_lo   (.clk(clk), .rst(rst), .bus(bl));
  modn_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_hi   (.clk(clk), .rst(rst), .bus(bh));

  assign bh.en = bl.tc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b0.en = 0; b0.up_dn = 1; b0.load = 0; b0.load_val = '0;
    b1.en = 0; b1.up_dn = 1; b1.load = 0; b1.load_val = '0;
    b2.en = 0; b2.up_dn = 1; b2.load = 0; b2.load_val = '0;
    bl.en = 0; bl.up_dn = 1; bl.load = 0; bl.load_val = '0;
    bh.up_dn = 1; bh.load = 0; bh.load_val = '0;
  endtask

  task automatic do_reset();
    idle_all();
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    b0.en = 1; b0.load = 1; b0.load_val = 4'd7;
    rst = 1'b1;
    #1;
    n_checks++;
    if (b0.out !== 4'd0) begin n_errors++; $display("FAIL reset_out: got %0d want 0", b0.out); end
    n_checks++;
    if (b0.load_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", b0.load_err); end
    step();
    n_checks++;
    if (b0.out !== 4'd0) begin n_errors++; $display("FAIL reset_ignores_load: got %0d want 0", b0.out); end
    b0.load = 0; b0.up_dn = 0;
    #1;
    n_checks++;
    if (b0.tc !== 1'b1) begin n_errors++; $display("FAIL reset_tc_down: got %b want 1", b0.tc); end
    b0.en = 0;
    #1;
    n_checks++;
    if (b0.tc !== 1'b0) begin n_errors++; $display("FAIL reset_tc_idle: got %b want 0", b0.tc); end
    rst = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_seq [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    do_reset();
    b0.en = 1; b0.up_dn = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (b0.out !== exp_seq[i]) begin n_errors++; $display("FAIL up_wrap_out[%0d]: got %0d want %0d", i, b0.out, exp_seq[i]); end
      n_checks++;
      if (b0.tc !== (exp_seq[i] == 4'd9)) begin n_errors++; $display("FAIL up_wrap_tc[%0d]: got %b want %b", i, b0.tc, exp_seq[i] == 4'd9); end
    end
    b0.en = 0;
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_seq [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
    do_reset();
    b0.load = 1; b0.load_val = 4'd2;
    step();
    n_checks++;
    if (b0.out !== 4'd2) begin n_errors++; $display("FAIL down_load2: got %0d want 2", b0.out); end
    b0.load = 0; b0.en = 1; b0.up_dn = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (b0.out !== exp_seq[i]) begin n_errors++; $display("FAIL down_wrap_out[%0d]: got %0d want %0d", i, b0.out, exp_seq[i]); end
      n_checks++;
      if (b0.tc !== (exp_seq[i] == 4'd0)) begin n_errors++; $display("FAIL down_wrap_tc[%0d]: got %b want %b", i, b0.tc, exp_seq[i] == 4'd0); end
    end
    b0.en = 0;
  endtask

  task automatic test_load();
    do_reset();
    b0.en = 1; b0.up_dn = 1; b0.load = 1; b0.load_val = 4'd7;
    step();
    n_checks++;
    if (b0.out !== 4'd7) begin n_errors++; $display("FAIL load7_out: got %0d want 7", b0.out); end
    n_checks++;
    if (b0.load_err !== 1'b0) begin n_errors++; $display("FAIL load7_err: got %b want 0", b0.load_err); end
    b0.load_val = 4'd12;
    step();
    n_checks++;
    if (b0.out !== 4'd0) begin n_errors++; $display("FAIL load12_out: got %0d want 0", b0.out); end
    n_checks++;
    if (b0.load_err !== 1'b1) begin n_errors++; $display("FAIL load12_err: got %b want 1", b0.load_err); end
    b0.load = 0; b0.en = 0;
    step();
    n_checks++;
    if (b0.load_err !== 1'b0) begin n_errors++; $display("FAIL load_err_oneshot: got %b want 0", b0.load_err); end
    b0.load = 1; b0.load_val = 4'd9;
    step();
    n_checks++;
    if (b0.out !== 4'd9 || b0.load_err !== 1'b0) begin n_errors++; $display("FAIL load9: got out=%0d err=%b want 9/0", b0.out, b0.load_err); end
    b0.en = 1; b0.up_dn = 1;
    #1;
    n_checks++;
    if (b0.tc !== 1'b0) begin n_errors++; $display("FAIL tc_masked_by_load: got %b want 0", b0.tc); end
    b0.load_val = 4'd10;
    step();
    n_checks++;
    if (b0.out !== 4'd0 || b0.load_err !== 1'b1) begin n_errors++; $display("FAIL load10: got out=%0d err=%b want 0/1", b0.out, b0.load_err); end
    b0.load = 0; b0.en = 0;
  endtask

  task automatic test_hold_and_dir();
    do_reset();
    b0.load = 1; b0.load_val = 4'd5;
    step();
    b0.load = 0; b0.en = 0; b0.up_dn = 1;
    step(); step(); step();
    n_checks++;
    if (b0.out !== 4'd5 || b0.tc !== 1'b0) begin n_errors++; $display("FAIL hold: got out=%0d tc=%b want 5/0", b0.out, b0.tc); end
    b0.en = 1;
    step();
    n_checks++;
    if (b0.out !== 4'd6) begin n_errors++; $display("FAIL dir_up: got %0d want 6", b0.out); end
    b0.up_dn = 0;
    step();
    n_checks++;
    if (b0.out !== 4'd5) begin n_errors++; $display("FAIL dir_turnaround: got %0d want 5", b0.out); end
    b0.en = 0;
  endtask

  task automatic test_saturate();
    do_reset();
    b1.load = 1; b1.load_val = 4'd8;
    step();
    b1.load = 0; b1.en = 1; b1.up_dn = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (b1.out !== 4'd9 || b1.tc !== 1'b1) begin n_errors++; $display("FAIL sat_up[%0d]: got out=%0d tc=%b want 9/1", i, b1.out, b1.tc); end
    end
    b1.up_dn = 0;
    step();
    n_checks++;
    if (b1.out !== 4'd8) begin n_errors++; $display("FAIL sat_turn_down: got %0d want 8", b1.out); end
    b1.load = 1; b1.load_val = 4'd0;
    step();
    b1.load = 0;
    step(); step();
    n_checks++;
    if (b1.out !== 4'd0 || b1.tc !== 1'b1) begin n_errors++; $display("FAIL sat_down: got out=%0d tc=%b want 0/1", b1.out, b1.tc); end
    b1.en = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    b0.load = 1; b0.load_val = 4'd5;
    step();
    b0.load = 0; b0.en = 1; b0.up_dn = 1;
    step();
    n_checks++;
    if (b0.out !== 4'd6) begin n_errors++; $display("FAIL async_pre: got %0d want 6", b0.out); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (b0.out !== 4'd0) begin n_errors++; $display("FAIL async_immediate: got %0d want 0", b0.out); end
    step();
    n_checks++;
    if (b0.out !== 4'd0) begin n_errors++; $display("FAIL async_no_count: got %0d want 0", b0.out); end
    rst = 1'b0;
    step();
    n_checks++;
    if (b0.out !== 4'd1) begin n_errors++; $display("FAIL async_first_count: got %0d want 1", b0.out); end
    b0.en = 0; b0.load = 1; b0.load_val = 4'd7;
    #2 rst = 1'b1;
    step();
    rst = 1'b0; b0.load = 0;
    step();
    n_checks++;
    if (b0.out !== 4'd0) begin n_errors++; $display("FAIL async_discard_load: got %0d want 0", b0.out); end
  endtask

  task automatic test_pow2();
    do_reset();
    b2.load = 1; b2.load_val = 4'd15;
    step();
    n_checks++;
    if (b2.out !== 4'd15 || b2.load_err !== 1'b0) begin n_errors++; $display("FAIL p2_load15: got out=%0d err=%b want 15/0", b2.out, b2.load_err); end
    b2.load = 0; b2.en = 1; b2.up_dn = 1;
    step();
    n_checks++;
    if (b2.out !== 4'd0) begin n_errors++; $display("FAIL p2_wrap_up: got %0d want 0", b2.out); end
    b2.up_dn = 0;
    step();
    n_checks++;
    if (b2.out !== 4'd15) begin n_errors++; $display("FAIL p2_wrap_down: got %0d want 15", b2.out); end
    b2.en = 0;
  endtask

  task automatic test_cascade();
    int lo_m = 0;
    int hi_m = 0;
    bit carry;
    do_reset();
    bl.en = 1; bl.up_dn = 1;
    for (int i = 1; i <= 100; i++) begin
      carry = (lo_m == 9);
      lo_m  = (lo_m + 1) % 10;
      if (carry) hi_m = (hi_m + 1) % 10;
      step();
      n_checks++;
      if (bl.out !== 4'(lo_m) || bh.out !== 4'(hi_m)) begin
        n_errors++;
        $display("FAIL cascade[%0d]: got %0d%0d want %0d%0d", i, bh.out, bl.out, hi_m, lo_m);
      end
      if (i == 99) begin
        n_checks++;
        if (bh.out !== 4'd9 || bl.out !== 4'd9) begin n_errors++; $display("FAIL cascade_99: got %0d%0d want 99", bh.out, bl.out); end
      end
    end
    n_checks++;
    if (bh.out !== 4'd0 || bl.out !== 4'd0) begin n_errors++; $display("FAIL cascade_100: got %0d%0d want 00", bh.out, bl.out); end
    bl.en = 0;
  endtask

  initial begin
    idle_all();
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_hold_and_dir();
    test_saturate();
    test_async_reset();
    test_pow2();
    test_cascade();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/modn_updown_counter.md
MODN_UPDOWN_COUNTER -- requirements
Module: modn_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 10, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
REQ-003 The block SHALL have parameter SATURATE, default 0; 0 means wrap at the ends, 1 means hold at the ends.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  count enable.
REQ-007 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value to load.
REQ-010 out  output  WIDTH  registered count.
REQ-011 tc  output  1  combinational terminal-count / carry-out.
REQ-012 load_err  output  1  registered one-cycle flag for an out-of-range load.

Function
REQ-013 Priority on each edge SHALL be: rst, then load, then en, then hold.
REQ-014 Load with load_val < MODULUS SHALL set out = load_val on the next edge, regardless of en and up_dn.
REQ-015 Load with load_val >= MODULUS SHALL set out = 0 and assert load_err for exactly the following cycle.
REQ-016 load_err SHALL be 0 in every other cycle.
REQ-017 With en=1, up_dn=1, load=0 and out < MODULUS-1, out SHALL increment by 1.
REQ-018 With en=1, up_dn=1 and out = MODULUS-1: out SHALL become 0 when SATURATE=0; out SHALL hold MODULUS-1 when SATURATE=1.
REQ-019 With en=1, up_dn=0 and out > 0, out SHALL decrement by 1.
REQ-020 With en=1, up_dn=0 and out = 0: out SHALL become MODULUS-1 when SATURATE=0; out SHALL hold 0 when SATURATE=1.
REQ-021 With en=0 and load=0, out SHALL hold its value.
REQ-022 tc SHALL be asserted when en=1 and load=0 and either (up_dn=1 and out = MODULUS-1) or (up_dn=0 and out = 0).
REQ-023 tc SHALL be deasserted in all other cases; in SATURATE=1 mode tc SHALL stay high while the counter is held at the end value with en=1.
REQ-024 Cascading SHALL work by driving a higher stage's en from the lower stage's tc; stages SHALL share clk and rst, and no extra latency SHALL be introduced.
REQ-025 A change of up_dn SHALL take effect on the next edge; there SHALL be no turnaround cycle.
REQ-026 out SHALL never hold a value >= MODULUS.
REQ-027 All arithmetic SHALL be WIDTH bits, with no overflow into unused codes; MODULUS = 2**WIDTH SHALL be legal and wrap naturally.
REQ-028 Illegal parameter values SHALL stop elaboration with an error.

Reset
REQ-029 Asserting rst SHALL immediately, without waiting for clk, set out = 0 and load_err = 0.
REQ-030 tc SHALL follow REQ-022 from the reset value of out.
REQ-031 While rst=1, load and en SHALL be ignored.
REQ-032 The first count SHALL occur on the first rising clk edge after rst falls.
REQ-033 Asserting rst mid-count or mid-load SHALL discard the pending operation.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-034 Up-count wrap: rst pulse, then en=1, up_dn=1 for 12 edges -> out = 1..9, 0, 1, 2; tc high only while out=9.
REQ-035 Down-count wrap: load 2, then en=1, up_dn=0 for 4 edges -> out = 1, 0, 9, 8; tc high only while out=0.
REQ-036 Load priority and error: load=1 with en=1 and load_val=7 -> out=7; then load_val=12 -> out=0 and load_err=1 for one cycle.
REQ-037 Saturate (SATURATE=1): count up from 8 for 4 edges -> out = 9, 9, 9, 9 with tc held high; then up_dn=0 -> out=8.
REQ-038 Async reset: assert rst between edges while out=6 -> out=0 before the next clk edge; there is no count on the edge where rst is still high.
REQ-039 Cascade: two instances, the high stage's en driven by the low stage's tc, counting up for 100 edges from 00 -> the pair reads 99, then 00; the high stage increments only on edges where low = 9.
